crc_receiver: RTL and testbench
===============================

# crc_receiver

Downstream stage of the CRC transmitter. Accepts one BW+CRC_BW-bit codeword per handshake (payload in the upper BW bits, CRC in the lower CRC_BW bits). Recomputes the CRC over the payload with a STEP-bit-per-cycle LFSR and compares it with the received CRC. Returns the payload with a pass/fail flag and keeps running frame and error counters for link monitoring.

## Interface
- BW, 40, payload width in bits; must be a multiple of STEP.
- CRC_BW, 8, CRC width in bits.
- POLY, 8'h07, generator polynomial, implicit top bit. CRC-8 ATM by default.
- STEP, 8, payload bits processed per CALC cycle.
- CNT_W, 16, width of the frame and error counters.
- clk  input  1  sole clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- in_codeword  input  BW+CRC_BW  codeword {payload, crc}.
- in_valid  input  1  codeword valid.
- in_ready  output  1  block can accept a codeword.
- out_payload  output  BW  payload of the checked frame.
- out_crc_err  output  1  1 means received CRC ≠ computed CRC.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- frame_cnt  output  CNT_W  frames delivered, wraps modulo 2^CNT_W.
- err_cnt  output  CNT_W  frames delivered with out_crc_err=1, saturates at all-ones.

## Operation
- CRC convention: initial value 0, MSB-first, no reflection, no final XOR. This matches the transmitter codeword.
- FSM states are IDLE, CALC and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, register the codeword, clear the CRC register and step counter, and go to CALC.
- CALC:
  - in_ready=0.
  - Each cycle feeds the next STEP payload bits, MSB first, through the LFSR: crc = (crc<<1) ^ (POLY if shifted-out bit ^ data bit).
  - After BW/STEP cycles, latch out_crc_err = (crc ≠ received crc) and out_payload, then go to DONE.
- DONE:
  - out_valid=1.
  - out_payload and out_crc_err are held stable while out_ready=0.
  - On out_valid&out_ready:
    - frame_cnt += 1.
    - err_cnt += out_crc_err, unless err_cnt is already all-ones.
    - Leave DONE.
  - in_ready = out_ready while in DONE. If in_valid is also high on that edge, the new codeword is captured and the state goes directly to CALC. Otherwise it goes to IDLE.
- The codeword is sampled only on the accepting edge; later changes to in_codeword are ignored.
- Reset values, all outputs: in_ready=1, out_valid=0, out_crc_err=0, out_payload=0, frame_cnt=0, err_cnt=0. State is IDLE.
- Reset asserted mid-frame (CALC or DONE) aborts the frame immediately. No counter increments and no output for that frame.

## Timing
- Acceptance edge = edge 0. CALC edges are 1..BW/STEP. out_valid rises after edge BW/STEP (default 5).
- Latency from the acceptance edge to the first possible output handshake is BW/STEP+1 edges (default 6).
- Maximum throughput is one frame per BW/STEP+1 cycles. This needs out_ready held high and in_valid presented back-to-back.
- Counters update on the output handshake edge and are visible the following cycle.
- in_ready is combinational from state and out_ready. There is no combinational path from in_valid to any output.

## Test plan
- Reset:
  - Hold rstn=0 for 2 cycles → in_ready=1, out_valid=0, frame_cnt=0, err_cnt=0.
  - Drive in_valid=1 while in reset → nothing is accepted.
- Good frames with out_ready=1:
  - Send 48'h000000000000 → out_valid after 6 edges, out_payload=40'h0, out_crc_err=0.
  - Then send 48'h000000000107 (CRC-8 of payload 0x01 is 0x07) → out_crc_err=0, frame_cnt=2, err_cnt=0.
- Corrupt frames:
  - Send 48'h000000000106 → out_crc_err=1, err_cnt=1.
  - Send 48'h800000000107 (payload MSB flipped) → out_crc_err=1, err_cnt=2.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid → outputs stable, in_ready=0, counters unchanged.
  - Raise out_ready with in_valid=1 → handshake, frame_cnt increments, next codeword captured on the same edge, next out_valid 6 edges later.
- Saturation and wrap with CNT_W=4:
  - 20 corrupt frames → err_cnt stops at 4'hF, frame_cnt = 20 mod 16 = 4.
- Mid-frame reset:
  - Assert rstn=0 during CALC, cycle 3 → out_valid=0 and counters 0 after reset.
  - Release reset and send a good frame → correct result, frame_cnt=1.

Source files
------------

// File: rtl/crc_receiver.sv
// CRC receiver: recomputes an MSB-first CRC over the payload of each accepted
// codeword, STEP bits per cycle, and reports pass/fail plus frame/error counters.
module crc_receiver #(
   parameter int                BW     = 40,
   parameter int                CRC_BW = 8,
   parameter logic [CRC_BW-1:0] POLY   = 8'h07,
   parameter int                STEP   = 8,
   parameter int                CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [BW+CRC_BW-1:0] in_codeword,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [BW-1:0]        out_payload,
   output logic                 out_crc_err,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [CNT_W-1:0]     frame_cnt,
   output logic [CNT_W-1:0]     err_cnt
);

   localparam int NSTEP = BW / STEP;
   localparam int SCW   = (NSTEP > 1) ? $clog2(NSTEP) : 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t              state, state_next;
   logic [BW-1:0]       payload_q;
   logic [BW-1:0]       data_q;
   logic [CRC_BW-1:0]   rx_crc_q;
   logic [CRC_BW-1:0]   crc_q;
   logic [CRC_BW-1:0]   crc_next;
   logic [SCW-1:0]      step_q;
   logic                last_step;
   logic                accept;
   logic                out_hs;

   assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready;
   assign out_hs    = out_valid && out_ready;
   assign last_step = (step_q == SCW'(NSTEP - 1));

   // One LFSR step per payload bit; data_q is consumed from its MSB end.
   always_comb begin
      crc_next = crc_q;
      for (int i = 0; i < STEP; i++) begin
         crc_next = {crc_next[CRC_BW-2:0], 1'b0}
                  ^ ({CRC_BW{crc_next[CRC_BW-1] ^ data_q[BW-1-i]}} & POLY);
      end
   end

   // NOTE: every path assigns state_next first so no latch is inferred.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid) state_next = CALC;
         CALC:    if (last_step) state_next = DONE;
         DONE:    if (out_ready) state_next = in_valid ? CALC : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         payload_q   <= '0;
         data_q      <= '0;
         rx_crc_q    <= '0;
         crc_q       <= '0;
         step_q      <= '0;
         out_payload <= '0;
         out_crc_err <= 1'b0;
      end else if (accept) begin
         payload_q <= in_codeword[BW+CRC_BW-1:CRC_BW];
         data_q    <= in_codeword[BW+CRC_BW-1:CRC_BW];
         rx_crc_q  <= in_codeword[CRC_BW-1:0];
         crc_q     <= '0;
         step_q    <= '0;
      end else if (state == CALC) begin
         data_q <= data_q << STEP;
         crc_q  <= crc_next;
         step_q <= step_q + 1'b1;
         if (last_step) begin
            out_payload <= payload_q;
            out_crc_err <= (crc_next != rx_crc_q);
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         frame_cnt <= '0;
         err_cnt   <= '0;
      end else if (out_hs) begin
         frame_cnt <= frame_cnt + 1'b1;
         if (out_crc_err && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_crc_receiver.sv
// Scoreboard bench for crc_receiver: default instance plus a CNT_W=4 instance
// for counter saturation and wrap.
module tb_crc_receiver;

   typedef struct {
      logic [39:0] payload;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [47:0] in_codeword = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [39:0] out_payload;
   logic        out_crc_err;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] frame_cnt;
   logic [15:0] err_cnt;

   logic [47:0] in_codeword4 = '0;
   logic        in_valid4 = 1'b0;
   logic        in_ready4;
   logic [39:0] out_payload4;
   logic        out_crc_err4;
   logic        out_valid4;
   logic        out_ready4 = 1'b1;
   logic [3:0]  frame_cnt4;
   logic [3:0]  err_cnt4;

   exp_t sb_q[$];
   exp_t sb4_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   crc_receiver dut (
      .clk(clk), .rstn(rstn), .in_codeword(in_codeword), .in_valid(in_valid),
      .in_ready(in_ready), .out_payload(out_payload), .out_crc_err(out_crc_err),
      .out_valid(out_valid), .out_ready(out_ready), .frame_cnt(frame_cnt),
      .err_cnt(err_cnt)
   );

   crc_receiver #(.CNT_W(4)) dut4 (
      .clk(clk), .rstn(rstn), .in_codeword(in_codeword4), .in_valid(in_valid4),
      .in_ready(in_ready4), .out_payload(out_payload4), .out_crc_err(out_crc_err4),
      .out_valid(out_valid4), .out_ready(out_ready4), .frame_cnt(frame_cnt4),
      .err_cnt(err_cnt4)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s", name);
   endtask

   // Monitors: pop the expected result whenever a handshake is seen.
   always @(negedge clk) begin
      if (rstn && out_valid && out_ready) begin
         if (sb_q.size() == 0) fail_now("unexpected_output");
         else begin
            exp_t e;
            e = sb_q.pop_front();
            check("payload", 64'(out_payload), 64'(e.payload));
            check("crc_err", 64'(out_crc_err), 64'(e.err));
         end
      end
   end

   always @(negedge clk) begin
      if (rstn && out_valid4 && out_ready4) begin
         if (sb4_q.size() == 0) fail_now("unexpected_output4");
         else begin
            exp_t e;
            e = sb4_q.pop_front();
            check("payload4", 64'(out_payload4), 64'(e.payload));
            check("crc_err4", 64'(out_crc_err4), 64'(e.err));
         end
      end
   end

   // Caller is at posedge+1; returns at posedge+1 of the accepting edge.
   task automatic send(input logic [47:0] cw, input logic exp_err);
      bit ok = 0;
      exp_t e;
      e.payload = cw[47:8];
      e.err     = exp_err;
      sb_q.push_back(e);
      in_codeword = cw;
      in_valid    = 1'b1;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1; break; end
      end
      if (!ok) fail_now("send_timeout");
      @(posedge clk);
      #1;
      in_valid    = 1'b0;
      in_codeword = {$urandom, $urandom};
   endtask

   task automatic wait_hs();
      bit ok = 0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (out_valid && out_ready) begin ok = 1; break; end
      end
      if (!ok) fail_now("handshake_timeout");
      @(posedge clk);
      #1;
   endtask

   task automatic send4(input logic [47:0] cw, input logic exp_err);
      bit ok = 0;
      exp_t e;
      e.payload = cw[47:8];
      e.err     = exp_err;
      sb4_q.push_back(e);
      in_codeword4 = cw;
      in_valid4    = 1'b1;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (in_ready4) begin ok = 1; break; end
      end
      if (!ok) fail_now("send4_timeout");
      @(posedge clk);
      #1;
      in_valid4 = 1'b0;
      ok = 0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (out_valid4) begin ok = 1; break; end
      end
      if (!ok) fail_now("handshake4_timeout");
      @(posedge clk);
      #1;
   endtask

   initial begin
      int early;

      // Reset, with in_valid asserted throughout.
      in_valid    = 1'b1;
      in_codeword = 48'h123456789A_BC;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
      check("rst_err_cnt", 64'(err_cnt), 64'd0);
      check("rst_out_payload", 64'(out_payload), 64'd0);
      in_valid = 1'b0;
      rstn     = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      check("rst_nothing_accepted", 64'(out_valid), 64'd0);

      // Good frame of zeros, with exact output latency.
      send(48'h000000000000, 1'b0);
      early = 0;
      repeat (4) begin
         @(posedge clk);
         #1;
         if (out_valid) early++;
      end
      check("latency_early", 64'(early), 64'd0);
      @(posedge clk);
      #1;
      check("latency_valid_after_5", 64'(out_valid), 64'd1);
      wait_hs();
      check("frame_cnt_1", 64'(frame_cnt), 64'd1);

      // Good frame: CRC-8 of payload 0x01 is 0x07.
      send(48'h000000000107, 1'b0);
      wait_hs();
      check("frame_cnt_2", 64'(frame_cnt), 64'd2);
      check("err_cnt_0", 64'(err_cnt), 64'd0);

      // Corrupt CRC byte, then corrupt payload MSB.
      send(48'h000000000106, 1'b1);
      wait_hs();
      check("err_cnt_1", 64'(err_cnt), 64'd1);
      send(48'h800000000107, 1'b1);
      wait_hs();
      check("err_cnt_2", 64'(err_cnt), 64'd2);
      check("frame_cnt_4", 64'(frame_cnt), 64'd4);

      // Backpressure: hold the result for 10 cycles.
      out_ready = 1'b0;
      send(48'h000000000107, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      check("bp_valid", 64'(out_valid), 64'd1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_payload !== 40'h01 || out_crc_err !== 1'b0 || !out_valid ||
             in_ready || frame_cnt !== 16'd4 || err_cnt !== 16'd2) begin
            check("bp_hold_payload", 64'(out_payload), 64'h01);
            check("bp_hold_in_ready", 64'(in_ready), 64'd0);
            check("bp_hold_frame_cnt", 64'(frame_cnt), 64'd4);
         end else checks++;
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(48'h0000000002_0E, 1'b0);
      check("bp_frame_cnt_5", 64'(frame_cnt), 64'd5);
      early = 0;
      repeat (4) begin
         @(posedge clk);
         #1;
         if (out_valid) early++;
      end
      check("bp_next_early", 64'(early), 64'd0);
      @(posedge clk);
      #1;
      check("bp_next_valid", 64'(out_valid), 64'd1);
      wait_hs();
      check("frame_cnt_6", 64'(frame_cnt), 64'd6);
      check("err_cnt_still_2", 64'(err_cnt), 64'd2);

      // Reset during CALC cycle 3 aborts the frame.
      send(48'h000000000106, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b0;
      sb_q.delete();
      #1;
      check("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check("mid_rst_frame_cnt", 64'(frame_cnt), 64'd0);
      check("mid_rst_err_cnt", 64'(err_cnt), 64'd0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      check("mid_rst_no_output", 64'(out_valid), 64'd0);
      send(48'h000000000107, 1'b0);
      wait_hs();
      check("after_rst_frame_cnt", 64'(frame_cnt), 64'd1);
      check("after_rst_err_cnt", 64'(err_cnt), 64'd0);

      // CNT_W=4 instance: 20 corrupt frames.
      for (int i = 0; i < 20; i++) begin
         if (i[0]) send4(48'h000000000001, 1'b1);
         else      send4(48'h000000000106, 1'b1);
         if (i == 14) check("sat_err_cnt_15", 64'(err_cnt4), 64'hF);
         if (i == 15) begin
            check("wrap_frame_cnt_0", 64'(frame_cnt4), 64'd0);
            check("sat_err_cnt_hold", 64'(err_cnt4), 64'hF);
         end
      end
      check("sat_err_cnt_final", 64'(err_cnt4), 64'hF);
      check("wrap_frame_cnt_final", 64'(frame_cnt4), 64'd4);

      repeat (2) @(posedge clk);
      check("sb_empty", 64'(sb_q.size()), 64'd0);
      check("sb4_empty", 64'(sb4_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

endmodule
